vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Arbitrates a single-port synchronous image RAM (frame buffer) between two requesters:
  - the VGA scan-out pixel fetcher (read-only);
  - the filter CPU's load/store path (read/write).
- Sits between the processor core, the VGA timing/pixel path and the frame-buffer BRAM in the Asteroid top level.
- VGA has fixed priority so scan-out never tears; a wait counter guarantees the CPU forward progress.

Parameters:
- ADDR_W, 17, frame-buffer address width (word addresses).
- DATA_W, 8, pixel/data width.
- STARVE_LIMIT, 4, consecutive unserved CPU request cycles after which the CPU wins one arbitration (range 1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- vga_req  in  1  VGA read request; held with vga_addr stable until vga_ack
- vga_addr  in  ADDR_W  VGA read address
- vga_ack  out  1  combinational; request accepted this cycle
- vga_rdata  out  DATA_W  read data, valid when vga_rvalid=1
- vga_rvalid  out  1  one-cycle read-data strobe
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1=write, 0=read; qualified by cpu_req
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  combinational; request accepted this cycle
- cpu_rdata  out  DATA_W  read data, valid when cpu_rvalid=1
- cpu_rvalid  out  1  one-cycle read-data strobe; never pulses for writes
- mem_en  out  1  registered RAM enable
- mem_we  out  1  registered RAM write enable
- mem_addr  out  ADDR_W  registered RAM address
- mem_wdata  out  DATA_W  registered RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en (1-cycle sync RAM)

Behaviour:
- Reset (synchronous, active-high, clk):
  - mem_en, mem_we, vga_rvalid, cpu_rvalid, vga_ack and cpu_ack are 0.
  - mem_addr, mem_wdata, vga_rdata and cpu_rdata are 0.
  - Wait counter and in-flight read tags are cleared.
  - Reads in flight when reset asserts are dropped; no rvalid is produced after reset.
- Arbitration (cycle N, combinational on the current requests):
  - Only cpu_req=1 -> grant CPU.
  - Only vga_req=1 -> grant VGA.
  - Both requests -> grant VGA, unless wait_cnt == STARVE_LIMIT, in which case grant CPU.
  - The granted requester sees ack=1 in cycle N. It may present a new request in N+1, giving one access per cycle sustained.
- Issue (cycle N+1): mem_en=1, mem_we=granted we (VGA always 0), mem_addr/mem_wdata from the granted request. mem_en=0 in any cycle following a no-grant cycle.
- Read return:
  - A 2-entry tag pipeline records owner and read flag.
  - In cycle N+2 the owner's rvalid=1 and its rdata = mem_rdata; rdata is muxed from the tag and held until the next rvalid.
  - Read latency is ack to rvalid = 2 cycles. Back-to-back reads from mixed owners return in order with correct tags.
- Writes: acked like reads; no rvalid. A CPU read issued the cycle after a write to the same address returns the new data (RAM write-first assumed by the memory wrapper).
- wait_cnt (8 bit, saturating at STARVE_LIMIT):
  - +1 each cycle with cpu_req=1 && cpu_ack=0.
  - Cleared on cpu_ack or when cpu_req=0.
- cpu_we and cpu_wdata are ignored while cpu_req=0. A requester dropping req without ack is legal; nothing is issued.
- Address is passed unmodified; no wrap or bounds check.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_vga_grants (32, count of VGA acks) and stat_cpu_stalls (32, count of cycles with cpu_req=1 && cpu_ack=0).
  - Both are cleared by reset and wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold reset 3 cycles with both requests high -> all outputs 0, no ack, no mem_en; first ack in the cycle after reset deasserts.
- VGA read: RAM[0x00010]=0xA5, vga_req at cycle 0 -> vga_ack@0, mem_en=1/mem_addr=0x00010@1, vga_rvalid=1 with vga_rdata=0xA5@2, cpu_rvalid stays 0.
- Contention: vga_req held continuously, cpu_req from cycle 0 (STARVE_LIMIT=4) -> vga_ack@0..3, cpu_ack@4 only, vga_ack@5; stall counter (if enabled) = 4.
- CPU write/read-back: write 0x3C to 0x1FFFF, then read 0x1FFFF -> mem_we=1 once, cpu_rvalid only for the read, cpu_rdata=0x3C two cycles after its ack.
- Interleaved: alternate VGA read 0x00001 (=0x11) and CPU read 0x00002 (=0x22) every cycle -> rvalid strobes alternate owners, each with the correct data, none lost or swapped.
- Reset mid-flight: assert reset the cycle after a VGA ack -> no vga_rvalid afterward, mem_en=0, wait_cnt=0.

Source files
------------

// File: rtl/vram_arbiter.sv
// Frame-buffer arbiter: VGA scan-out has fixed priority, and a starvation counter guarantees CPU progress.
// Optional VRAM_ARB_STATS_EN adds grant/stall statistics outputs.
module vram_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_vga_grants,
    output logic [31:0]       stat_cpu_stalls
`endif
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0]        wait_cnt;
    logic              starved;
    logic              tag1_rd, tag1_cpu;
    logic              tag2_rd, tag2_cpu;
    logic [DATA_W-1:0] vga_hold, cpu_hold;

    always_comb begin
        starved = (wait_cnt == LIMIT);
        vga_ack = 1'b0;
        cpu_ack = 1'b0;
        if (!reset) begin
            if (cpu_req && (!vga_req || starved)) begin
                cpu_ack = 1'b1;
            end else if (vga_req) begin
                vga_ack = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tag1_rd   <= 1'b0;
            tag1_cpu  <= 1'b0;
            tag2_rd   <= 1'b0;
            tag2_cpu  <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            mem_en <= vga_ack | cpu_ack;
            mem_we <= cpu_ack & cpu_we;
            if (cpu_ack) begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end else if (vga_ack) begin
                mem_addr  <= vga_addr;
            end
            // Tag pipeline: stage 1 covers the issue cycle, stage 2 the cycle RAM data is valid
            tag1_rd  <= vga_ack | (cpu_ack & ~cpu_we);
            tag1_cpu <= cpu_ack;
            tag2_rd  <= tag1_rd;
            tag2_cpu <= tag1_cpu;
            if (!cpu_req || cpu_ack) begin
                wait_cnt <= '0;
            end else if (!starved) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    assign vga_rvalid = tag2_rd & ~tag2_cpu & ~reset;
    assign cpu_rvalid = tag2_rd &  tag2_cpu & ~reset;

    // Read data passes straight through on the strobe cycle and is held afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_hold <= '0;
            cpu_hold <= '0;
        end else begin
            if (vga_rvalid) vga_hold <= mem_rdata;
            if (cpu_rvalid) cpu_hold <= mem_rdata;
        end
    end

    assign vga_rdata = vga_rvalid ? mem_rdata : vga_hold;
    assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_hold;

`ifdef VRAM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_vga_grants <= '0;
            stat_cpu_stalls <= '0;
        end else begin
            if (vga_ack) stat_vga_grants <= stat_vga_grants + 32'd1;
            if (cpu_req && !cpu_ack) stat_cpu_stalls <= stat_cpu_stalls + 32'd1;
        end
    end
`endif

endmodule
